// File: rtl/functs.sv
// -----------------------------------------------------------------------------
// functs -- shared Q-format constants for the fixed-point arithmetic blocks
// (multiply, dequantize, divide).
//
// BITS      : number of fractional bits of the Q format
// QUANT_VAL : value of 1.0 in that format (1 << BITS)
// Q_WIDTH   : default operand width of the fixed-point blocks
// SAT_MAX   : largest positive Q_WIDTH-bit value (clamp for positive overflow)
// SAT_MIN   : most negative Q_WIDTH-bit value (clamp for negative overflow)
// -----------------------------------------------------------------------------
package functs;

    localparam int BITS      = 10;
    localparam int QUANT_VAL = 1 << BITS;
    localparam int Q_WIDTH   = 32;

    localparam logic [Q_WIDTH-1:0] SAT_MAX = {1'b0, {(Q_WIDTH-1){1'b1}}};
    localparam logic [Q_WIDTH-1:0] SAT_MIN = {1'b1, {(Q_WIDTH-1){1'b0}}};

endpackage : functs

// File: rtl/fixed_div_q10.sv
// -----------------------------------------------------------------------------
// fixed_div_q10 -- signed Q(BITS) fixed-point divider.
//
// Computes trunc((dividend * 2^BITS) / divisor) with C-style truncation toward
// zero, saturating to the signed DATA_WIDTH range. The quotient magnitude is
// built by a restoring radix-2 divider, one bit per clock, over the
// (DATA_WIDTH+BITS)-bit scaled numerator magnitude.
//
// Ports
//   clock           : sole clock, rising edge
//   reset           : asynchronous, active-high
//   in_valid        : dividend/divisor pair valid
//   in_ready        : block idle and able to accept a pair
//   in_dividend     : signed Q(BITS) dividend
//   in_divisor      : signed Q(BITS) divisor
//   out_valid       : result valid
//   out_ready       : consumer accepts the result
//   out_quotient    : signed Q(BITS) quotient (saturated)
//   out_div_by_zero : result came from a zero divisor
// -----------------------------------------------------------------------------
module fixed_div_q10 #(
    parameter int DATA_WIDTH = functs::Q_WIDTH,
    parameter int BITS       = functs::BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_dividend,
    input  logic [DATA_WIDTH-1:0] in_divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_quotient,
    output logic                  out_div_by_zero
);

    localparam int NW = DATA_WIDTH + BITS;   // scaled numerator / quotient width
    localparam int CW = $clog2(NW);

    localparam logic [DATA_WIDTH-1:0] POS_SAT = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] NEG_SAT = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    // Largest representable magnitudes: 2^(W-1)-1 positive, 2^(W-1) negative.
    localparam logic [NW-1:0] POS_LIM = NW'(POS_SAT);
    localparam logic [NW-1:0] NEG_LIM = NW'(NEG_SAT);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] rem;        // partial remainder, always < divisor magnitude
    logic [DATA_WIDTH-1:0] dvs;        // divisor magnitude
    logic [NW-1:0]         num;        // numerator magnitude, consumed MSB first
    logic [NW-1:0]         quo;        // quotient magnitude, built LSB first
    logic                  neg;        // result sign

    logic                  accept;
    logic                  divisor_zero;
    logic                  last_iter;
    logic [DATA_WIDTH-1:0] dividend_mag;
    logic [DATA_WIDTH-1:0] divisor_mag;
    logic [DATA_WIDTH:0]   rem_shift;
    logic [DATA_WIDTH:0]   trial;
    logic                  take;
    logic [DATA_WIDTH-1:0] rem_next;
    logic [NW-1:0]         quo_next;
    logic [DATA_WIDTH-1:0] result;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;

    // Magnitudes are kept unsigned, so -2^(W-1) maps to 2^(W-1) without overflow.
    assign dividend_mag = in_dividend[DATA_WIDTH-1] ? -in_dividend : in_dividend;
    assign divisor_mag  = in_divisor[DATA_WIDTH-1]  ? -in_divisor  : in_divisor;
    assign divisor_zero = (in_divisor == '0);
    assign last_iter    = (count == CW'(NW - 1));

    // One restoring step: shift in the next numerator bit, subtract if it fits.
    assign rem_shift = {rem, num[NW-1]};
    assign trial     = rem_shift - {1'b0, dvs};
    assign take      = ~trial[DATA_WIDTH];
    assign rem_next  = take ? trial[DATA_WIDTH-1:0] : rem_shift[DATA_WIDTH-1:0];
    assign quo_next  = {quo[NW-2:0], take};

    // Apply sign and saturation to the completed magnitude. A zero magnitude
    // yields plain zero whatever the sign.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave it unassigned and infer a latch.
        result = '0;
        if (quo_next == '0) begin
            result = '0;
        end else if (!neg) begin
            result = (quo_next > POS_LIM) ? POS_SAT : quo_next[DATA_WIDTH-1:0];
        end else begin
            result = (quo_next > NEG_LIM) ? NEG_SAT : -quo_next[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept)               state_next = divisor_zero ? DONE : CALC;
            CALC: if (last_iter)            state_next = DONE;
            DONE: if (out_valid & out_ready) state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count           <= '0;
            rem             <= '0;
            dvs             <= '0;
            num             <= '0;
            quo             <= '0;
            neg             <= 1'b0;
            out_quotient    <= '0;
            out_div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        count           <= '0;
                        rem             <= '0;
                        quo             <= '0;
                        num             <= {dividend_mag, {BITS{1'b0}}};
                        dvs             <= divisor_mag;
                        neg             <= in_dividend[DATA_WIDTH-1] ^ in_divisor[DATA_WIDTH-1];
                        out_div_by_zero <= divisor_zero;
                        if (divisor_zero) begin
                            out_quotient <= in_dividend[DATA_WIDTH-1] ? NEG_SAT : POS_SAT;
                        end
                    end
                end
                CALC: begin
                    rem   <= rem_next;
                    num   <= {num[NW-2:0], 1'b0};
                    quo   <= quo_next;
                    count <= count + CW'(1);
                    // The final step registers the formatted result directly,
                    // so it is on the output when DONE is entered.
                    if (last_iter) out_quotient <= result;
                end
                default: ;
            endcase
        end
    end

endmodule : fixed_div_q10

// File: tb/tb_fixed_div_q10.sv
// -----------------------------------------------------------------------------
// tb_fixed_div_q10 -- self-checking bench for fixed_div_q10.
// Expected results are pushed to a scoreboard queue when a pair is issued and
// popped when the divider presents its result. Latency is counted in clock
// edges with the accepting edge counted as edge 1.
// -----------------------------------------------------------------------------
module tb_fixed_div_q10;
    import functs::*;

    localparam int W      = 32;
    localparam int LAT    = 43;
    localparam int LAT_DZ = 1;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_dividend;
    logic [W-1:0] in_divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_quotient;
    logic         out_div_by_zero;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] q;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t sb[$];

    fixed_div_q10 #(.DATA_WIDTH(W), .BITS(BITS)) dut (
        .clock           (clock),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_dividend     (in_dividend),
        .in_divisor      (in_divisor),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_quotient    (out_quotient),
        .out_div_by_zero (out_div_by_zero)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: C-style truncating division of the scaled dividend, saturated.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint n;
        longint d;
        longint q;
        e.dbz = (b == '0);
        e.lat = e.dbz ? LAT_DZ : LAT;
        if (e.dbz) begin
            e.q = a[W-1] ? SAT_MIN : SAT_MAX;
        end else begin
            n = longint'($signed(a)) * QUANT_VAL;
            d = longint'($signed(b));
            q = n / d;
            if (q > 64'sd2147483647)       e.q = SAT_MAX;
            else if (q < -64'sd2147483648) e.q = SAT_MIN;
            else                           e.q = q[W-1:0];
        end
        return e;
    endfunction

    // Drive one pair until accepted; returns at the negedge after the accept edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("in_ready_before_issue", W'(in_ready), W'(1));
        in_valid    = 1'b1;
        in_dividend = a;
        in_divisor  = b;
        @(posedge clock);
        @(negedge clock);
        in_valid    = 1'b0;
        in_dividend = $urandom;
        in_divisor  = $urandom;
        check("in_ready_after_accept", W'(in_ready), W'(0));
    endtask

    // Wait for out_valid, then pop and compare against the scoreboard.
    task automatic collect(input string tag);
        int   edges = 1;
        exp_t e;
        while (!out_valid && edges < 200) begin
            @(posedge clock);
            edges++;
            @(negedge clock);
        end
        if (sb.size() == 0) begin
            check({tag, "_scoreboard_empty"}, W'(0), W'(1));
        end else begin
            e = sb.pop_front();
            check({tag, "_valid"},   W'(out_valid),       W'(1));
            check({tag, "_latency"}, W'(edges),           W'(e.lat));
            check({tag, "_q"},       out_quotient,        e.q);
            check({tag, "_dbz"},     W'(out_div_by_zero), W'(e.dbz));
        end
    endtask

    // Single-cycle out_ready; in_ready must be back the following cycle.
    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        out_ready = 1'b0;
        check({tag, "_ready_after_pop"}, W'(in_ready),  W'(1));
        check({tag, "_valid_after_pop"}, W'(out_valid), W'(0));
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic dbz);
        exp_t e;
        e.q   = q;
        e.dbz = dbz;
        e.lat = dbz ? LAT_DZ : LAT;
        sb.push_back(e);
        issue(a, b);
        collect(tag);
        release_out(tag);
    endtask

    task automatic do_model_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e = model(a, b);
        do_op(tag, a, b, e.q, e.dbz);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           seen;

        reset       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        repeat (2) @(negedge clock);
        check("reset_in_ready",  W'(in_ready),        W'(1));
        check("reset_out_valid", W'(out_valid),       W'(0));
        check("reset_q",         out_quotient,        '0);
        check("reset_dbz",       W'(out_div_by_zero), W'(0));
        reset = 1'b0;
        @(negedge clock);

        do_op("one_by_one",   32'h0000_0400, 32'h0000_0400, 32'h0000_0400, 1'b0);
        do_op("third",        32'h0000_0400, 32'h0000_0C00, 32'h0000_0155, 1'b0);
        do_op("neg_third",    32'hFFFF_FC00, 32'h0000_0C00, 32'hFFFF_FEAB, 1'b0);
        do_op("neg_3_over_2", 32'hFFFF_F400, 32'h0000_0800, 32'hFFFF_FA00, 1'b0);
        do_op("dz_pos",       32'h0000_0005, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1);
        do_op("dz_neg",       32'hFFFF_FFFB, 32'h0000_0000, 32'h8000_0000, 1'b1);
        do_op("dz_zero",      32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1);
        do_op("sat_pos",      32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0);
        do_op("sat_neg",      32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0);
        do_op("min_by_m1",    32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        do_op("min_by_min",   32'h8000_0000, 32'h8000_0000, 32'h0000_0400, 1'b0);
        do_op("exact_min",    32'hFFE0_0000, 32'h0000_0001, 32'h8000_0000, 1'b0);
        do_op("just_over",    32'h0020_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0);
        do_op("no_neg_zero",  32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0);
        do_op("zero_div",     32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 1'b0);

        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            do_model_op($sformatf("rand%0d", i), a, b);
        end

        // Output back-pressure: result held, inputs ignored while DONE.
        sb.push_back(model(32'h0000_0400, 32'h0000_0400));
        issue(32'h0000_0400, 32'h0000_0400);
        collect("stall");
        for (int i = 0; i < 10; i++) begin
            in_valid    = i[0];
            in_dividend = $urandom;
            in_divisor  = 32'h0000_0005;
            @(posedge clock);
            @(negedge clock);
            check($sformatf("stall%0d_q", i),     out_quotient,  32'h0000_0400);
            check($sformatf("stall%0d_ready", i), W'(in_ready),  W'(0));
            check($sformatf("stall%0d_valid", i), W'(out_valid), W'(1));
        end
        // A zero-divisor pair offered on the output handshake edge must not
        // be taken (it would otherwise show up as out_valid right away).
        in_valid   = 1'b1;
        in_divisor = '0;
        out_ready  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("pop_edge_no_accept_valid", W'(out_valid), W'(0));
        check("pop_edge_no_accept_ready", W'(in_ready),  W'(1));

        // Reset in the middle of CALC aborts the operation.
        issue(32'h0000_0400, 32'h0000_0400);
        repeat (19) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("abort_async_ready", W'(in_ready),  W'(1));
        check("abort_async_valid", W'(out_valid), W'(0));
        @(negedge clock);
        reset = 1'b0;
        check("abort_q",   out_quotient,        '0);
        check("abort_dbz", W'(out_div_by_zero), W'(0));
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (out_valid) seen++;
        end
        check("abort_no_result", W'(seen), W'(0));
        do_op("after_abort", 32'h0000_0800, 32'h0000_0400, 32'h0000_0800, 1'b0);

        check("scoreboard_drained", W'(sb.size()), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fixed_div_q10
